// File: rtl/tile_map_pkg.sv
// Shared types and brick-pattern helper for the tile map generator.
package tile_map_pkg;

   localparam int unsigned EMPTY_TILE_DFLT = 12;

   // Tile indices for the upper and lower halves of a brick, indexed by phase.
   localparam int unsigned UPPER [4] = '{8, 10, 6, 8};
   localparam int unsigned LOWER [4] = '{9, 11, 7, 9};

   typedef enum logic [2:0] {
      FILL,
      IDLE,
      HIT_RD,
      HIT_CHK,
      HIT_WR0,
      HIT_WR1
   } state_e;

   // Staggered brick layout: every pair of rows shifts the brick by two columns.
   function automatic int unsigned brick_pattern(input int unsigned x,
                                                 input int unsigned y,
                                                 input int unsigned brick_rows,
                                                 input int unsigned empty_tile);
      int unsigned p;
      logic [1:0]  phase;
      if (y >= brick_rows) return empty_tile;
      p     = y >> 1;
      phase = {x[1] ^ p[0], x[0]};
      return y[0] ? LOWER[phase] : UPPER[phase];
   endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port synchronous RAM: port A read-only, port B read/write.
module tile_map_ram #(
   parameter int unsigned DEPTH = 4800,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned AW    = 13
) (
   input  logic             clk_i,
   input  logic [AW-1:0]    a_addr_i,
   output logic [WIDTH-1:0] a_rdata_o,
   input  logic             b_we_i,
   input  logic [AW-1:0]    b_addr_i,
   input  logic [WIDTH-1:0] b_wdata_i,
   output logic [WIDTH-1:0] b_rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] a_rdata_q;
   logic [WIDTH-1:0] b_rdata_q;

   // One-cycle registered reads on both ports; port B also writes.
   always_ff @(posedge clk_i) begin
      a_rdata_q <= mem_q[a_addr_i];
      b_rdata_q <= mem_q[b_addr_i];
      if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
   end

   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/tile_map_generator.sv
// Writable tile map: self-filling brick pattern, pipelined display lookups,
// ball-hit brick clearing and remaining-brick count.
module tile_map_generator
   import tile_map_pkg::*;
#(
   parameter int unsigned MAP_W      = 80,
   parameter int unsigned MAP_H      = 60,
   parameter int unsigned X_BITS     = 7,
   parameter int unsigned Y_BITS     = 7,
   parameter int unsigned TILE_BITS  = 4,
   parameter int unsigned BRICK_ROWS = 4,
   parameter int unsigned EMPTY_TILE = EMPTY_TILE_DFLT
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fill,
   input  logic                 i_rd_valid,
   input  logic [X_BITS-1:0]    i_tile_x,
   input  logic [Y_BITS-1:0]    i_tile_y,
   output logic                 o_rd_valid,
   output logic [TILE_BITS-1:0] o_tile_no,
   input  logic                 i_hit_valid,
   input  logic [X_BITS-1:0]    i_hit_x,
   input  logic [Y_BITS-1:0]    i_hit_y,
   output logic                 o_hit_ready,
   output logic                 o_hit_done,
   output logic                 o_hit_was_brick,
   output logic                 o_busy,
   output logic [15:0]          o_bricks_left,
   output logic                 o_all_cleared
);

   localparam int unsigned DEPTH  = MAP_W * MAP_H;
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BRICKS = MAP_W * BRICK_ROWS / 2;
   localparam logic [TILE_BITS-1:0] EMPTY = TILE_BITS'(EMPTY_TILE);

   function automatic logic in_map(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
      return (32'(x) < MAP_W) && (32'(y) < MAP_H);
   endfunction

   function automatic logic [AW-1:0] map_addr(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
      return AW'(32'(y) * MAP_W + 32'(x));
   endfunction

   state_e                state_q, state_d;
   logic [AW-1:0]         fill_addr_q, fill_addr_d;
   logic [X_BITS-1:0]     fill_x_q, fill_x_d;
   logic [Y_BITS-1:0]     fill_y_q, fill_y_d;
   logic [X_BITS-1:0]     hit_x_q, hit_x_d;
   logic [Y_BITS-1:0]     hit_y_q, hit_y_d;
   logic                  hit_inr_q, hit_inr_d;
   logic [15:0]           bricks_q, bricks_d;
   logic                  done_q, done_d;
   logic                  was_brick_q, was_brick_d;

   logic                  rd_v1_q, rd_oor1_q, rd_valid_q;
   logic [TILE_BITS-1:0]  tile_q;

   logic                  a_inr;
   logic [AW-1:0]         a_addr;
   logic [TILE_BITS-1:0]  a_rdata;
   logic                  b_we;
   logic [AW-1:0]         b_addr, hit_addr, pair_addr;
   logic [TILE_BITS-1:0]  b_wdata, b_rdata;

   // Out-of-range coordinates are steered to address 0; their data is discarded.
   assign a_inr     = in_map(i_tile_x, i_tile_y);
   assign a_addr    = a_inr ? map_addr(i_tile_x, i_tile_y) : '0;
   assign hit_addr  = hit_inr_q ? map_addr(hit_x_q, hit_y_q) : '0;
   assign pair_addr = map_addr(hit_x_q, hit_y_q ^ Y_BITS'(1));

   tile_map_ram #(
      .DEPTH (DEPTH),
      .WIDTH (TILE_BITS),
      .AW    (AW)
   ) u_ram (
      .clk_i     (i_clk),
      .a_addr_i  (a_addr),
      .a_rdata_o (a_rdata),
      .b_we_i    (b_we),
      .b_addr_i  (b_addr),
      .b_wdata_i (b_wdata),
      .b_rdata_o (b_rdata)
   );

   // Two-stage display pipeline: RAM read, then range/fill masking.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rd_v1_q    <= 1'b0;
         rd_oor1_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         tile_q     <= EMPTY;
      end else begin
         rd_v1_q    <= i_rd_valid;
         rd_oor1_q  <= !a_inr;
         rd_valid_q <= rd_v1_q;
         tile_q     <= (rd_oor1_q || state_q == FILL) ? EMPTY : a_rdata;
      end
   end

   // FSM and control state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= FILL;
         fill_addr_q <= '0;
         fill_x_q    <= '0;
         fill_y_q    <= '0;
         hit_x_q     <= '0;
         hit_y_q     <= '0;
         hit_inr_q   <= 1'b0;
         bricks_q    <= '0;
         done_q      <= 1'b0;
         was_brick_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         fill_x_q    <= fill_x_d;
         fill_y_q    <= fill_y_d;
         hit_x_q     <= hit_x_d;
         hit_y_q     <= hit_y_d;
         hit_inr_q   <= hit_inr_d;
         bricks_q    <= bricks_d;
         done_q      <= done_d;
         was_brick_q <= was_brick_d;
      end
   end

   // Next-state logic and port B control for fill and hit sequences.
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      fill_x_d    = fill_x_q;
      fill_y_d    = fill_y_q;
      hit_x_d     = hit_x_q;
      hit_y_d     = hit_y_q;
      hit_inr_d   = hit_inr_q;
      bricks_d    = bricks_q;
      done_d      = 1'b0;
      was_brick_d = 1'b0;
      b_we        = 1'b0;
      b_addr      = hit_addr;
      b_wdata     = EMPTY;
      unique case (state_q)
         FILL: begin
            b_we    = 1'b1;
            b_addr  = fill_addr_q;
            b_wdata = TILE_BITS'(brick_pattern(32'(fill_x_q), 32'(fill_y_q), BRICK_ROWS, EMPTY_TILE));
            if (fill_addr_q == AW'(DEPTH - 1)) begin
               state_d  = IDLE;
               bricks_d = 16'(BRICKS);
            end else begin
               fill_addr_d = fill_addr_q + AW'(1);
               if (fill_x_q == X_BITS'(MAP_W - 1)) begin
                  fill_x_d = '0;
                  fill_y_d = fill_y_q + Y_BITS'(1);
               end else begin
                  fill_x_d = fill_x_q + X_BITS'(1);
               end
            end
         end
         IDLE: begin
            if (i_fill) begin
               state_d     = FILL;
               fill_addr_d = '0;
               fill_x_d    = '0;
               fill_y_d    = '0;
            end else if (i_hit_valid) begin
               state_d   = HIT_RD;
               hit_x_d   = i_hit_x;
               hit_y_d   = i_hit_y;
               hit_inr_d = in_map(i_hit_x, i_hit_y);
            end
         end
         HIT_RD: state_d = HIT_CHK;
         HIT_CHK: begin
            if (hit_inr_q && 32'(hit_y_q) < BRICK_ROWS && b_rdata != EMPTY) begin
               state_d = HIT_WR0;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         HIT_WR0: begin
            b_we    = 1'b1;
            state_d = HIT_WR1;
         end
         HIT_WR1: begin
            b_we        = 1'b1;
            b_addr      = pair_addr;
            bricks_d    = (bricks_q != '0) ? bricks_q - 16'd1 : bricks_q;
            done_d      = 1'b1;
            was_brick_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = FILL;
      endcase
   end

   assign o_rd_valid      = rd_valid_q;
   assign o_tile_no       = tile_q;
   assign o_hit_ready     = (state_q == IDLE);
   assign o_hit_done      = done_q;
   assign o_hit_was_brick = was_brick_q;
   assign o_busy          = (state_q != IDLE);
   assign o_bricks_left   = bricks_q;
   assign o_all_cleared   = (bricks_q == '0) && (state_q != FILL);

endmodule

// File: tb/tb_tile_map_generator.sv
// Scoreboard bench for tile_map_generator on an 8x6 map with 4 brick rows.
module tb_tile_map_generator;

   localparam int W = 8;
   localparam int H = 6;
   localparam int BR = 4;
   localparam int EMPTY = 12;

   logic       clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_fill = 1'b0;
   logic       i_rd_valid = 1'b0;
   logic [3:0] i_tile_x = '0;
   logic [3:0] i_tile_y = '0;
   logic       o_rd_valid;
   logic [3:0] o_tile_no;
   logic       i_hit_valid = 1'b0;
   logic [3:0] i_hit_x = '0;
   logic [3:0] i_hit_y = '0;
   logic       o_hit_ready, o_hit_done, o_hit_was_brick, o_busy, o_all_cleared;
   logic [15:0] o_bricks_left;

   tile_map_generator #(
      .MAP_W(W), .MAP_H(H), .X_BITS(4), .Y_BITS(4),
      .TILE_BITS(4), .BRICK_ROWS(BR), .EMPTY_TILE(EMPTY)
   ) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_fill(i_fill),
      .i_rd_valid(i_rd_valid), .i_tile_x(i_tile_x), .i_tile_y(i_tile_y),
      .o_rd_valid(o_rd_valid), .o_tile_no(o_tile_no),
      .i_hit_valid(i_hit_valid), .i_hit_x(i_hit_x), .i_hit_y(i_hit_y),
      .o_hit_ready(o_hit_ready), .o_hit_done(o_hit_done),
      .o_hit_was_brick(o_hit_was_brick), .o_busy(o_busy),
      .o_bricks_left(o_bricks_left), .o_all_cleared(o_all_cleared)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_miss = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model
   int mmap [H][W];
   int m_bricks = 0;
   bit filling = 1'b0;

   function automatic int pat(int x, int y);
      int up [4] = '{8, 10, 6, 8};
      int lo [4] = '{9, 11, 7, 9};
      int ph;
      if (y >= BR) return EMPTY;
      ph = (((x >> 1) ^ (y >> 1)) & 1) * 2 + (x & 1);
      return (y % 2 == 1) ? lo[ph] : up[ph];
   endfunction

   function automatic void model_fill();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            mmap[y][x] = pat(x, y);
      m_bricks = W * BR / 2;
   endfunction

   function automatic int model_tile(int x, int y);
      if (filling || x >= W || y >= H) return EMPTY;
      return mmap[y][x];
   endfunction

   typedef struct { int due; int val; } exp_t;
   exp_t rd_q[$];
   exp_t hit_q[$];

   // Output monitor: pops expectations when results appear, flags missing/extra.
   always @(negedge clk) begin
      exp_t e;
      if (o_rd_valid === 1'b1) begin
         if (rd_q.size() == 0) expect_eq("rd_spurious", o_rd_valid, 0);
         else begin
            e = rd_q.pop_front();
            expect_eq("rd_latency", cyc, e.due);
            expect_eq("rd_tile", o_tile_no, e.val);
         end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         expect_eq("rd_valid", o_rd_valid, 1);
         void'(rd_q.pop_front());
      end
      if (o_hit_done === 1'b1) begin
         if (hit_q.size() == 0) expect_eq("hit_spurious", o_hit_done, 0);
         else begin
            e = hit_q.pop_front();
            expect_eq("hit_latency", cyc, e.due);
            expect_eq("hit_was_brick", o_hit_was_brick, e.val);
         end
      end else if (hit_q.size() > 0 && hit_q[0].due <= cyc) begin
         expect_eq("hit_done", o_hit_done, 1);
         void'(hit_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rd_issue(input int x, input int y);
      exp_t e;
      i_rd_valid = 1'b1;
      i_tile_x = 4'(x);
      i_tile_y = 4'(y);
      e.due = cyc + 2;
      e.val = model_tile(x, y);
      rd_q.push_back(e);
      tick();
   endtask

   task automatic rd_end();
      int budget = 10;
      i_rd_valid = 1'b0;
      while (rd_q.size() > 0 && budget > 0) begin tick(); budget--; end
      if (rd_q.size() > 0) begin
         expect_eq("rd_drain", rd_q.size(), 0);
         rd_q.delete();
      end
   endtask

   task automatic do_hit(input int x, input int y);
      exp_t e;
      int budget = 20;
      bit brick;
      i_hit_valid = 1'b1;
      i_hit_x = 4'(x);
      i_hit_y = 4'(y);
      while (o_hit_ready !== 1'b1 && budget > 0) begin tick(); budget--; end
      expect_eq("hit_ready", o_hit_ready, 1);
      tick();
      i_hit_valid = 1'b0;
      brick = (x < W && y < H && y < BR && mmap[y][x] != EMPTY);
      if (brick) begin
         mmap[y][x] = EMPTY;
         mmap[y ^ 1][x] = EMPTY;
         if (m_bricks > 0) m_bricks--;
      end
      e.due = cyc + (brick ? 4 : 2);
      e.val = brick;
      hit_q.push_back(e);
      budget = 10;
      while (hit_q.size() > 0 && budget > 0) begin tick(); budget--; end
      if (hit_q.size() > 0) begin
         expect_eq("hit_drain", hit_q.size(), 0);
         hit_q.delete();
      end
   endtask

   task automatic wait_idle(input int start, input string tag);
      int budget = 200;
      while (o_busy !== 1'b0 && budget > 0) begin tick(); budget--; end
      expect_eq(tag, cyc - start, W * H);
   endtask

   task automatic rd_map(input int rows);
      for (int y = 0; y < rows; y++)
         for (int x = 0; x < W; x++)
            rd_issue(x, y);
      rd_end();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      // Reset values
      repeat (3) tick();
      expect_eq("rst_rd_valid", o_rd_valid, 0);
      expect_eq("rst_tile_no", o_tile_no, EMPTY);
      expect_eq("rst_hit_ready", o_hit_ready, 0);
      expect_eq("rst_hit_done", o_hit_done, 0);
      expect_eq("rst_was_brick", o_hit_was_brick, 0);
      expect_eq("rst_busy", o_busy, 1);
      expect_eq("rst_bricks", o_bricks_left, 0);
      expect_eq("rst_all_cleared", o_all_cleared, 0);
      i_rst_n = 1'b1;
      start = cyc;
      wait_idle(start, "fill_len");
      model_fill();
      expect_eq("bricks_init", o_bricks_left, m_bricks);
      expect_eq("all_cleared_init", o_all_cleared, 0);

      // Spot reads, out-of-range, and an 8-deep back-to-back burst
      for (int x = 0; x < 4; x++) rd_issue(x, 0);
      rd_issue(0, 2);
      rd_issue(1, 3);
      rd_issue(5, 4);
      rd_issue(9, 0);
      rd_issue(0, 7);
      for (int x = 0; x < W; x++) rd_issue(x, 1);
      rd_end();

      // Brick hit and repeat
      do_hit(2, 1);
      rd_issue(2, 0);
      rd_issue(2, 1);
      rd_end();
      expect_eq("bricks_after_hit", o_bricks_left, 15);
      do_hit(2, 1);
      expect_eq("bricks_repeat", o_bricks_left, 15);

      // Misses: below brick rows and off-map
      do_hit(3, 5);
      do_hit(9, 0);
      rd_map(H);
      expect_eq("bricks_after_miss", o_bricks_left, m_bricks);

      // Clear every brick
      for (int p = 0; p < BR / 2; p++)
         for (int x = 0; x < W; x++)
            do_hit(x, 2 * p);
      expect_eq("bricks_zero", o_bricks_left, 0);
      expect_eq("all_cleared", o_all_cleared, 1);

      // Re-fill with a simultaneous hit request that must be dropped
      i_fill = 1'b1;
      i_hit_valid = 1'b1;
      i_hit_x = 4'd0;
      i_hit_y = 4'd0;
      tick();
      i_fill = 1'b0;
      i_hit_valid = 1'b0;
      start = cyc;
      filling = 1'b1;
      repeat (3) tick();
      expect_eq("fill_busy", o_busy, 1);
      expect_eq("fill_ready", o_hit_ready, 0);
      expect_eq("fill_all_cleared", o_all_cleared, 0);
      for (int x = 0; x < 4; x++) rd_issue(x, 0);
      rd_end();
      filling = 1'b0;
      wait_idle(start, "refill_len");
      model_fill();
      expect_eq("bricks_refill", o_bricks_left, m_bricks);
      expect_eq("all_cleared_refill", o_all_cleared, 0);
      rd_map(BR);

      // Reset during HIT_WR0
      i_hit_valid = 1'b1;
      i_hit_x = 4'd5;
      i_hit_y = 4'd3;
      tick();
      i_hit_valid = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      start = cyc;
      expect_eq("midrst_bricks", o_bricks_left, 0);
      expect_eq("midrst_busy", o_busy, 1);
      expect_eq("midrst_done", o_hit_done, 0);
      wait_idle(start, "midrst_fill_len");
      model_fill();
      expect_eq("midrst_bricks_after", o_bricks_left, m_bricks);
      rd_issue(5, 3);
      rd_issue(5, 2);
      rd_issue(0, 0);
      rd_end();

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/tile_map_generator.md
Name: tile_map_generator

Overview:
- RAM-backed, parametrised replacement for the fixed brick-pattern background lookup.
- Holds a writable MAP_W×MAP_H tile map. On reset or request it self-fills with the staggered brick pattern.
- Serves pipelined per-pixel tile lookups to the renderer. Accepts ball-hit requests that clear bricks and counts the bricks remaining.
- Sits between the VGA timing/tile-coordinate logic and the tile ROM/pixel mux.

Parameters:
MAP_W, 80, tiles per row
MAP_H, 60, tile rows
X_BITS, 7, tile-x coordinate width
Y_BITS, 7, tile-y coordinate width
TILE_BITS, 4, tile index width
BRICK_ROWS, 4, top rows holding bricks (even, ≥2)
EMPTY_TILE, 12, tile index for background / cleared cell

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_fill  in  1  pulse: re-fill map with brick pattern
i_rd_valid  in  1  lookup request qualifier
i_tile_x  in  X_BITS  lookup column
i_tile_y  in  Y_BITS  lookup row
o_rd_valid  out  1  lookup result valid
o_tile_no  out  TILE_BITS  looked-up tile index
i_hit_valid  in  1  hit request
i_hit_x  in  X_BITS  hit column
i_hit_y  in  Y_BITS  hit row
o_hit_ready  out  1  hit request accepted when high
o_hit_done  out  1  one-cycle pulse: hit processed
o_hit_was_brick  out  1  valid with o_hit_done
o_busy  out  1  fill or hit in progress
o_bricks_left  out  16  remaining brick cells
o_all_cleared  out  1  high when o_bricks_left==0 and not filling

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous, active-low, on i_rst_n.
- Reset values: o_rd_valid=0, o_tile_no=EMPTY_TILE, o_hit_ready=0, o_hit_done=0, o_hit_was_brick=0, o_busy=1, o_bricks_left=0, o_all_cleared=0. FSM enters FILL with address 0.
- Memory: dual-port, MAP_W*MAP_H entries, address = y*MAP_W+x.
  - Port A is display read-only.
  - Port B is FSM read/write.
- Brick pattern for row y < BRICK_ROWS:
  - pair p = y>>1.
  - phase = {x[1]^p[0], x[0]}.
  - Even y: UPPER[phase] with UPPER = {8,10,6,8}.
  - Odd y: LOWER[phase] with LOWER = {9,11,7,9}.
  - Rows ≥ BRICK_ROWS: EMPTY_TILE.
- Display path:
  - Latency 2: o_rd_valid(N+2) = i_rd_valid(N), with o_tile_no matching.
  - Out-of-range coordinate (x≥MAP_W or y≥MAP_H) returns EMPTY_TILE.
  - While FSM is in FILL, o_tile_no is forced to EMPTY_TILE.
  - Throughput: 1 lookup per cycle.
- FSM states and transitions:
  - FILL: write pattern(addr) at one address per cycle, addr 0..MAP_W*MAP_H-1. After the last write, load o_bricks_left = MAP_W*BRICK_ROWS/2 and go to IDLE. Duration = MAP_W*MAP_H cycles.
  - IDLE: o_hit_ready=1, o_busy=0.
    - i_fill → FILL (addr 0). i_fill has priority over a simultaneous i_hit_valid; that hit is not accepted.
    - i_hit_valid → latch coordinates, go to HIT_RD.
  - HIT_RD: read (x,y) on port B → HIT_CHK.
  - HIT_CHK: brick = in-range && y<BRICK_ROWS && tile≠EMPTY_TILE.
    - If brick → HIT_WR0.
    - Else pulse o_hit_done with was_brick=0 → IDLE.
  - HIT_WR0: write EMPTY_TILE at (x,y) → HIT_WR1.
  - HIT_WR1: write EMPTY_TILE at (x,y^1), decrement o_bricks_left, pulse o_hit_done with was_brick=1 → IDLE.
- Handshake: a hit is accepted only in a cycle where i_hit_valid && o_hit_ready. Requests outside IDLE are ignored; the requester holds i_hit_valid until o_hit_ready.
- i_fill outside IDLE is ignored. An in-progress hit completes first.
- Reset mid-fill or mid-hit: FSM restarts FILL, no o_hit_done is issued, and the counter is cleared.
- o_bricks_left never decrements below 0. A repeat hit on a cleared cell returns was_brick=0.

Decomposition:
- Package tile_map_pkg holds:
  - UPPER/LOWER brick tables and EMPTY_TILE default.
  - FSM state enum: FILL, IDLE, HIT_RD, HIT_CHK, HIT_WR0, HIT_WR1.
  - brick_pattern(x,y) function.
- Sub-module: tile_map_ram, a simple dual-port synchronous RAM, 1-cycle read, parameter depth/width.

Test Plan (MAP_W=8, MAP_H=6, BRICK_ROWS=4):
- Reset, then 48 cycles → o_busy falls; o_bricks_left=16; reads (0..3,0) → 8,10,6,8; (0,2) → 6; (1,3) → 9; (5,4) → 12.
- Back-to-back reads on 8 consecutive cycles → o_rd_valid exactly 2 cycles after each request, values match pattern, no gaps.
- Hit (2,1) → o_hit_done with was_brick=1 after 4 cycles; reads (2,0) and (2,1) → 12; o_bricks_left=15; repeat hit (2,1) → was_brick=0, count stays 15.
- Hit (3,5) and hit (9,0) → was_brick=0 each; map unchanged.
- Hit all 16 brick cells → o_all_cleared=1; then i_fill → reads return 12 during FILL, pattern restored after 48 cycles, o_bricks_left=16, o_all_cleared=0.
- i_rst_n low for 1 cycle during HIT_WR0 → no o_hit_done, FILL restarts, (x,y) holds its brick tile afterwards.
